// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a FIFO,
// a two-process FSM serializes them onto tx, and STATUS is readable in the same window.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [1:0]  data_size,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]    fifoMem [FIFO_DEPTH];

    logic sel, wrData, wrStatus, fifoEmpty, fifoFull;
    logic push, pop, txActive, bitEnd;
    logic unusedOk;

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wrData    = sel & mem_write & ~addr[2];
    assign wrStatus  = sel & mem_write & addr[2];
    assign fifoEmpty = (wptr_q == rptr_q);
    assign fifoFull  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A store to a full FIFO still fits when the transmitter frees a slot on the same edge.
    assign push      = wrData & (~fifoFull | pop);
    assign txActive  = (state_q != IDLE);
    assign busy      = txActive | ~fifoEmpty;
    assign bitEnd    = (cnt_q == CNT_LAST);
    assign tx        = tx_q;
    assign read_data = (sel & addr[2]) ?
                       {28'd0, overflow_q, txActive, fifoEmpty, fifoFull} : 32'd0;
    assign unusedOk  = ^{data_size, write_data[31:8], addr[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        if (state_q != IDLE) begin
            cnt_d = bitEnd ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    shift_d = fifoMem[rptr_q[AW-1:0]];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (bitEnd) begin
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        shift_d = fifoMem[rptr_q[AW-1:0]];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        if (state_q == START) begin
            tx_d = 1'b0;
        end else if (state_q == DATA) begin
            tx_d = shift_q[0];
        end
    end

    always_comb begin
        wptr_d     = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        overflow_d = overflow_q;
        if (wrStatus & write_data[3]) begin
            overflow_d = 1'b0;
        end
        if (wrData & fifoFull & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage is left unreset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wptr_q[AW-1:0]] <= write_data[7:0];
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios with randomized data, a
// serial-line receiver that decodes whole frames, and a byte-queue reference model.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [1:0]  data_size = 2'd0;
    logic        mem_write = 1'b0;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Receiver state: sees the tx line once per cycle and rebuilds whole frames.
    logic       inFrame = 1'b0;
    int         pos = 0;
    logic       frameBits [FRAME];
    int         framesStarted = 0;
    int         curStart = 0;
    int         frameErrs = 0;
    logic [7:0] rxByte;
    logic       shapeOk;
    logic [7:0] rxBytes [$];
    int         rxStarts [$];

    // Reference model: bytes that must appear on the line, FIFO occupancy, overflow flag.
    logic [7:0] expQ [$];
    int         modelCount = 0;
    logic       modelOvf = 1'b0;

    uart_tx_mmio #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .write_data(write_data),
        .data_size(data_size),
        .mem_write(mem_write),
        .read_data(read_data),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame receiver: a frame is CPB low cycles, eight CPB-long data bits, CPB high cycles.
    always @(negedge clk) begin
        if (rst) begin
            inFrame = 1'b0;
        end else if (!inFrame) begin
            if (tx === 1'b0) begin
                inFrame      = 1'b1;
                frameBits[0] = tx;
                pos          = 1;
                curStart     = cyc;
                framesStarted++;
            end
        end else begin
            frameBits[pos] = tx;
            pos++;
            if (pos == FRAME) begin
                shapeOk = 1'b1;
                for (int i = 0; i < CPB; i++) begin
                    if (frameBits[i] !== 1'b0) shapeOk = 1'b0;
                    if (frameBits[FRAME-CPB+i] !== 1'b1) shapeOk = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    rxByte[b] = frameBits[CPB*(b+1)];
                    for (int k = 1; k < CPB; k++) begin
                        if (frameBits[CPB*(b+1)+k] !== rxByte[b]) shapeOk = 1'b0;
                    end
                end
                if (!shapeOk) frameErrs++;
                rxBytes.push_back(rxByte);
                rxStarts.push_back(curStart);
                inFrame = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] statusModel(input logic active);
        return {28'd0, modelOvf, active, (modelCount == 0), (modelCount == DEPTH)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One store; returns at the negedge just after the edge that sampled it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write_data = d;
        data_size  = 2'($urandom_range(0, 3));
        mem_write  = 1'b1;
        @(negedge clk);
        mem_write  = 1'b0;
        addr       = 32'd0;
    endtask

    task automatic readStatus(output logic [31:0] v);
        addr      = BASE + 32'd4;
        mem_write = 1'b0;
        #1;
        v = read_data;
    endtask

    task automatic waitFrameStart(input string tag, input int fsRef);
        int n = 0;
        while (framesStarted == fsRef && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_start"}, framesStarted - fsRef, 32'd1);
    endtask

    task automatic drainAndCompare(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_count"}, rxBytes.size(), expQ.size());
        while (rxBytes.size() > 0 && expQ.size() > 0) begin
            checkOutput({tag, "_byte"}, {24'd0, rxBytes.pop_front()}, {24'd0, expQ.pop_front()});
        end
        rxBytes.delete();
        expQ.delete();
        checkOutput({tag, "_shape"}, frameErrs, 32'd0);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] a;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          ns;
        int          fs;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_held_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        readStatus(st);
        checkOutput("reset_status", st, 32'h2);

        // Single byte: latency, frame content, busy release
        @(negedge clk);
        fs = framesStarted;
        applyStimulus(BASE + 32'($urandom_range(0, 3)), 32'hFFFF_FFA5);
        ns = cyc;
        expQ.push_back(8'hA5);
        waitFrameStart("single", fs);
        checkOutput("single_latency", curStart - ns, 32'd2);
        while (cyc < ns + 40) @(negedge clk);
        checkOutput("single_busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("single_busy_drop", {31'd0, busy}, 32'd0);
        drainAndCompare("single");

        // Back-to-back frames
        rxStarts.delete();
        b0 = 8'h55;
        b1 = 8'h0F;
        applyStimulus(BASE, {24'($urandom()), b0});
        ns = cyc;
        applyStimulus(BASE + 32'd1, {24'($urandom()), b1});
        expQ.push_back(b0);
        expQ.push_back(b1);
        readStatus(st);
        checkOutput("b2b_status_active", {31'd0, st[2]}, 32'd1);
        while (cyc < ns + 40) @(negedge clk);
        readStatus(st);
        checkOutput("b2b_not_empty", {31'd0, st[1]}, 32'd0);
        @(negedge clk);
        readStatus(st);
        checkOutput("b2b_empty_after_pop", {31'd0, st[1]}, 32'd1);
        drainAndCompare("b2b");
        checkOutput("b2b_frames", rxStarts.size(), 32'd2);
        if (rxStarts.size() == 2) begin
            checkOutput("b2b_gap", rxStarts[1] - rxStarts[0], FRAME);
        end

        // Overflow with byte 0 in flight
        b0 = 8'($urandom());
        fs = framesStarted;
        applyStimulus(BASE, {24'($urandom()), b0});
        expQ.push_back(b0);
        waitFrameStart("ovf", fs);
        modelCount = 0;
        modelOvf   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(BASE + 32'($urandom_range(0, 3)), {24'($urandom()), 8'(i)});
            if (modelCount < DEPTH) begin
                expQ.push_back(8'(i));
                modelCount++;
            end else begin
                modelOvf = 1'b1;
            end
        end
        readStatus(st);
        checkOutput("ovf_status", st, statusModel(1'b1));
        applyStimulus(BASE + 32'd4, 32'h8);
        modelOvf = 1'b0;
        readStatus(st);
        checkOutput("ovf_cleared", st, statusModel(1'b1));

        // Full FIFO, store lands on the STOP-end pop edge
        while (cyc < curStart + FRAME - 2) @(negedge clk);
        b1 = 8'($urandom());
        applyStimulus(BASE, {24'($urandom()), b1});
        expQ.push_back(b1);
        readStatus(st);
        checkOutput("full_pop_status", st, statusModel(1'b1));
        drainAndCompare("ovf");

        // Reset in the middle of data bit 3 with bytes queued
        fs = framesStarted;
        applyStimulus(BASE, {24'($urandom()), 8'($urandom())});
        waitFrameStart("midrst", fs);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(BASE, {24'($urandom()), 8'($urandom())});
        end
        addr = BASE + 32'd4;
        while (cyc < curStart + 4 + 3 * CPB + 1) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", {31'd0, tx}, 32'd1);
        checkOutput("midrst_status", read_data, 32'h2);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        fs = framesStarted;
        repeat (100) @(negedge clk);
        checkOutput("midrst_no_frames", framesStarted - fs, 32'd0);
        checkOutput("midrst_no_bytes", rxBytes.size(), 32'd0);
        checkOutput("midrst_idle_tx", {31'd0, tx}, 32'd1);

        // Just outside the window
        addr = BASE + 32'd8;
        #1;
        checkOutput("outside_load", read_data, 32'd0);
        applyStimulus(BASE + 32'd8, 32'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        checkOutput("outside_no_frames", framesStarted - fs, 32'd0);
        readStatus(st);
        checkOutput("outside_status", st, 32'h2);

        // Random traffic mixing in-window and out-of-window stores
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            if ($urandom_range(0, 3) != 0) begin
                b0 = 8'($urandom());
                applyStimulus(BASE + 32'($urandom_range(0, 3)), {24'($urandom()), b0});
                expQ.push_back(b0);
            end else begin
                a = $urandom();
                if (a[31:3] == BASE[31:3]) a = a ^ 32'h8000_0000;
                applyStimulus(a, $urandom());
            end
        end
        drainAndCompare("random");
        readStatus(st);
        checkOutput("random_status", st, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
